// File: rtl/uriscv_dmem_responder.sv
// Data-memory responder for the uRISC-V load/store port: accepts one request at a
// time, waits a fixed number of cycles, then performs the access on a byte-enabled
// word SRAM and returns a one-cycle ack with read data or an error flag.
module uriscv_dmem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_rd_i,
  input  logic [3:0]  mem_wr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_accept_o,
  output logic        mem_ack_o,
  output logic [31:0] mem_data_o,
  output logic        mem_error_o
);

  localparam int unsigned AW       = $clog2(MEM_WORDS);
  // Window size in bytes; 33 bits so a 2^30-word array does not wrap to zero.
  localparam logic [32:0] WinBytes = 33'(MEM_WORDS) << 2;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic [3:0]     strb_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic           ack_q;
  logic           err_q;
  logic [31:0]    rdata_q;
  logic [31:0]    mem_q [MEM_WORDS];

  logic           req;
  logic [31:0]    offset;
  logic [AW-1:0]  idx;
  logic           is_wr;
  logic           win_err;
  logic           strb_err;
  logic           acc_err;
  logic           do_access;
  logic           mem_we;

  assign req          = mem_rd_i | (|mem_wr_i);
  // Gated by rst_ni so no request is reported as taken while reset is held.
  assign mem_accept_o = rst_ni & (state_q == StIdle) & req;

  assign offset    = addr_q - BASE_ADDR;
  assign idx       = offset[AW+1:2];
  assign is_wr     = |strb_q;
  assign win_err   = {1'b0, offset} >= WinBytes;
  assign acc_err   = win_err | strb_err;
  assign do_access = (state_q == StBusy) && (cnt_q == 4'd0);
  assign mem_we    = do_access & is_wr & ~acc_err;

  // Strobe legality and alignment against the captured low address bits.
  always_comb begin
    strb_err = 1'b0;
    case (strb_q)
      4'b0000: strb_err = 1'b0;  // pure read
      4'b0001: strb_err = (addr_q[1:0] != 2'd0);
      4'b0010: strb_err = (addr_q[1:0] != 2'd1);
      4'b0100: strb_err = (addr_q[1:0] != 2'd2);
      4'b1000: strb_err = (addr_q[1:0] != 2'd3);
      4'b0011: strb_err = (addr_q[1:0] != 2'd0);
      4'b1100: strb_err = (addr_q[1:0] != 2'd2);
      4'b1111: strb_err = (addr_q[1:0] != 2'd0);
      default: strb_err = 1'b1;
    endcase
  end

  // Request FSM with registered ack, error and read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      strb_q  <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_data_i;
            strb_q  <= mem_wr_i;
            cnt_q   <= 4'(WAIT_STATES);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ack_q   <= 1'b1;
            state_q <= StIdle;
            if (acc_err) begin
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end else if (!is_wr) begin
              rdata_q <= mem_q[idx];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Byte-enabled array write; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign mem_ack_o   = ack_q;
  assign mem_error_o = err_q;
  assign mem_data_o  = rdata_q;

endmodule

// File: tb/tb_uriscv_dmem_responder.sv
// Directed bench: three responder instances with 0, 3 and 5 wait states.
module tb_uriscv_dmem_responder;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic        rd    [3];
  logic [3:0]  wr    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        accept[3];
  logic        ack   [3];
  logic [31:0] rdata [3];
  logic        err   [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uriscv_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .mem_rd_i(rd[0]), .mem_wr_i(wr[0]),
    .mem_addr_i(addr[0]), .mem_data_i(wdata[0]), .mem_accept_o(accept[0]),
    .mem_ack_o(ack[0]), .mem_data_o(rdata[0]), .mem_error_o(err[0])
  );
  uriscv_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_ni(rst_n[1]), .mem_rd_i(rd[1]), .mem_wr_i(wr[1]),
    .mem_addr_i(addr[1]), .mem_data_i(wdata[1]), .mem_accept_o(accept[1]),
    .mem_ack_o(ack[1]), .mem_data_o(rdata[1]), .mem_error_o(err[1])
  );
  uriscv_dmem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(5)) u_ws5 (
    .clk_i(clk), .rst_ni(rst_n[2]), .mem_rd_i(rd[2]), .mem_wr_i(wr[2]),
    .mem_addr_i(addr[2]), .mem_data_i(wdata[2]), .mem_accept_o(accept[2]),
    .mem_ack_o(ack[2]), .mem_data_o(rdata[2]), .mem_error_o(err[2])
  );

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : (u == 1) ? 5 : 7;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One request on instance u; checks accept, ack latency, error and optionally data.
  task automatic access(input int u, input logic r, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d, input logic e,
                        input logic cd, input logic [31:0] ed, input string tag);
    int seen;
    logic        e_obs;
    logic [31:0] d_obs;
    e_obs = 1'b0;
    d_obs = 32'd0;
    @(posedge clk); #1;
    rd[u] = r; wr[u] = s; addr[u] = a; wdata[u] = d;
    @(negedge clk);
    chk1({tag, ":accept"}, accept[u], 1'b1);
    @(posedge clk); #1;
    rd[u] = 1'b0; wr[u] = 4'd0;
    seen = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack[u]) begin
        seen  = c;
        e_obs = err[u];
        d_obs = rdata[u];
        break;
      end
    end
    chk32({tag, ":latency"}, 32'(seen), 32'(lat_of(u)));
    chk1({tag, ":error"}, e_obs, e);
    if (cd) chk32({tag, ":data"}, d_obs, ed);
    @(negedge clk);
    chk1({tag, ":ack_drop"}, ack[u], 1'b0);
    if (e) chk1({tag, ":err_drop"}, err[u], 1'b0);
  endtask

  initial begin
    rst_n = 3'b000;
    for (int u = 0; u < 3; u++) begin
      rd[u] = 1'b0; wr[u] = 4'd0; addr[u] = 32'd0; wdata[u] = 32'd0;
    end
    // Reset state, with a request pending to show accept stays low.
    rd[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst:accept", accept[0], 1'b0);
    chk1("rst:ack", ack[0], 1'b0);
    chk1("rst:err", err[0], 1'b0);
    chk32("rst:data", rdata[0], 32'd0);
    @(posedge clk); #1;
    rd[0] = 1'b0;
    rst_n = 3'b111;

    // Zero wait states: word write/read, byte lanes.
    access(0, 1'b0, 4'b1111, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, "wr_word");
    access(0, 1'b1, 4'b0000, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, "rd_word");
    access(0, 1'b0, 4'b0100, 32'h12, 32'h00AA_0000, 1'b0, 1'b1, 32'hDEAD_BEEF, "wr_byte2");
    access(0, 1'b1, 4'b0000, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAA_BEEF, "rd_byte2");
    access(0, 1'b0, 4'b1100, 32'h12, 32'h1234_0000, 1'b0, 1'b0, 32'h0, "wr_half_hi");
    access(0, 1'b1, 4'b0000, 32'h10, 32'h0, 1'b0, 1'b1, 32'h1234_BEEF, "rd_half_hi");

    // Window errors.
    access(0, 1'b0, 4'b1111, 32'hFFC, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, "wr_top");
    access(0, 1'b1, 4'b0000, 32'h1000, 32'h0, 1'b1, 1'b1, 32'h0, "rd_oow");
    access(0, 1'b0, 4'b1111, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 32'h0, "wr_oow");
    access(0, 1'b1, 4'b0000, 32'hFFC, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, "rd_top");

    // Strobe legality and alignment.
    access(0, 1'b0, 4'b1111, 32'h11, 32'h9999_9999, 1'b1, 1'b1, 32'h0, "mis_word");
    access(0, 1'b0, 4'b0011, 32'h13, 32'h9999_9999, 1'b1, 1'b0, 32'h0, "mis_half");
    access(0, 1'b0, 4'b0101, 32'h10, 32'h9999_9999, 1'b1, 1'b0, 32'h0, "bad_strb");
    access(0, 1'b0, 4'b0010, 32'h11, 32'h0000_7700, 1'b0, 1'b0, 32'h0, "wr_byte1");
    access(0, 1'b1, 4'b0000, 32'h10, 32'h0, 1'b0, 1'b1, 32'h1234_77EF, "rd_byte1");

    // Read and write together: write wins, read data held.
    access(0, 1'b1, 4'b0001, 32'h10, 32'h0000_0011, 1'b0, 1'b1, 32'h1234_77EF, "rdwr");
    access(0, 1'b1, 4'b0000, 32'h10, 32'h0, 1'b0, 1'b1, 32'h1234_7711, "rd_rdwr");

    // Three wait states, back-to-back reads held high.
    access(1, 1'b0, 4'b1111, 32'h40, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0, "ws3_wr");
    @(posedge clk); #1;
    rd[1] = 1'b1; addr[1] = 32'h40;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      chk1($sformatf("b2b:accept@%0d", c), accept[1], (c == 0) || (c == 5));
      chk1($sformatf("b2b:ack@%0d", c), ack[1], (c == 5) || (c == 10));
      if (c == 5 || c == 10) chk32($sformatf("b2b:data@%0d", c), rdata[1], 32'hA5A5_A5A5);
      if (c == 5) begin
        @(posedge clk); #1;
        rd[1] = 1'b0;
      end
    end

    // Five wait states: reset during a pending write discards it.
    access(2, 1'b0, 4'b1111, 32'h20, 32'h1111_2222, 1'b0, 1'b0, 32'h0, "ws5_wr");
    @(posedge clk); #1;
    wr[2] = 4'b1111; addr[2] = 32'h20; wdata[2] = 32'h5555_5555;
    @(negedge clk);
    chk1("ws5_pend:accept", accept[2], 1'b1);
    @(posedge clk); #1;
    wr[2] = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[2] = 1'b0;
    rd[2] = 1'b1;
    @(negedge clk);
    chk1("midrst:accept", accept[2], 1'b0);
    chk1("midrst:ack", ack[2], 1'b0);
    chk32("midrst:data", rdata[2], 32'd0);
    @(posedge clk); #1;
    rd[2] = 1'b0;
    rst_n[2] = 1'b1;
    begin
      logic any_ack;
      any_ack = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        any_ack = any_ack | ack[2];
      end
      chk1("midrst:no_ack", any_ack, 1'b0);
    end
    access(2, 1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, 1'b1, 32'h1111_2222, "midrst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
